// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: validates one RV32I memory request, issues a single word-aligned
// memory transaction and returns extended load data straight to the register file.
module ysyx_24100005_lsu #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int XLEN          = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_load,
  input  logic                     req_is_store,
  input  logic [2:0]               req_funct3,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  input  logic [RF_ADDR_WIDTH-1:0] req_rd,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [3:0]               mem_wmask,
  input  logic                     mem_resp_valid,
  input  logic [XLEN-1:0]          mem_rdata,
  output logic                     wb_wen,
  output logic [RF_ADDR_WIDTH-1:0] wb_waddr,
  output logic [XLEN-1:0]          wb_wdata,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               dbg_state_o
);

  // Handshakes: a request transfers on the rising edge where req_valid & req_ready;
  // the memory request transfers where mem_req_valid & mem_req_ready and then holds
  // no further obligation; the response is a single-cycle mem_resp_valid pulse in WAIT.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     is_load_q;
  logic [2:0]               funct3_q;
  logic [1:0]               off_q;
  logic [RF_ADDR_WIDTH-1:0] rd_q;
  logic                     mem_we_q;
  logic [XLEN-1:0]          mem_addr_q;
  logic [XLEN-1:0]          mem_wdata_q;
  logic [3:0]               mem_wmask_q;
  logic                     done_q;
  logic                     err_q;
  logic                     wb_wen_q;
  logic [RF_ADDR_WIDTH-1:0] wb_waddr_q;
  logic [XLEN-1:0]          wb_wdata_q;

  logic                     req_bad_d;
  logic [3:0]               st_wmask_d;
  logic [XLEN-1:0]          st_wdata_d;
  logic [XLEN-1:0]          ld_shift_d;
  logic [XLEN-1:0]          ld_data_d;

  always_comb begin
    req_bad_d = 1'b0;
    if (req_is_load == req_is_store) begin
      req_bad_d = 1'b1;
    end else if (req_is_load) begin
      case (req_funct3)
        3'b000, 3'b100: req_bad_d = 1'b0;
        3'b001, 3'b101: req_bad_d = req_addr[0];
        3'b010:         req_bad_d = |req_addr[1:0];
        default:        req_bad_d = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  req_bad_d = 1'b0;
        3'b001:  req_bad_d = req_addr[0];
        3'b010:  req_bad_d = |req_addr[1:0];
        default: req_bad_d = 1'b1;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte mask alone selects what lands.
  always_comb begin
    st_wmask_d = 4'b0000;
    st_wdata_d = '0;
    if (req_is_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_wmask_d = 4'b0001 << req_addr[1:0];
          st_wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          st_wmask_d = 4'b0011 << req_addr[1:0];
          st_wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          st_wmask_d = 4'b1111;
          st_wdata_d = req_wdata;
        end
      endcase
    end
  end

  assign ld_shift_d = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data_d = '0;
    case (funct3_q)
      3'b000:  ld_data_d = {{(XLEN-8){ld_shift_d[7]}}, ld_shift_d[7:0]};
      3'b001:  ld_data_d = {{(XLEN-16){ld_shift_d[15]}}, ld_shift_d[15:0]};
      3'b010:  ld_data_d = mem_rdata;
      3'b100:  ld_data_d = {{(XLEN-8){1'b0}}, ld_shift_d[7:0]};
      3'b101:  ld_data_d = {{(XLEN-16){1'b0}}, ld_shift_d[15:0]};
      default: ld_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      rd_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wb_wen_q    <= 1'b0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (req_bad_d) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              is_load_q   <= req_is_load;
              funct3_q    <= req_funct3;
              off_q       <= req_addr[1:0];
              rd_q        <= req_rd;
              mem_we_q    <= req_is_store;
              mem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
              mem_wdata_q <= st_wdata_d;
              mem_wmask_q <= st_wmask_d;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            if (is_load_q && (rd_q != '0)) begin
              wb_wen_q   <= 1'b1;
              wb_waddr_q <= rd_q;
              wb_wdata_q <= ld_data_d;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gating with rst keeps req_ready low for the whole reset window.
  assign req_ready     = (state_q == S_IDLE) & ~rst;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign wb_wen        = wb_wen_q;
  assign wb_waddr      = wb_waddr_q;
  assign wb_wdata      = wb_wdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/ysyx_24100005_lsu.md
YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_LSU

Interface
REQ-001 SHALL have parameter RF_ADDR_WIDTH, default 5, the register-file address width of wb_waddr and req_rd.
REQ-002 SHALL have parameter XLEN, default 32, the data and address width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, upstream load/store request valid.
REQ-006 SHALL have port req_ready, output, 1, LSU can accept a request.
REQ-007 SHALL have port req_is_load / req_is_store, input, 1 each, operation type.
REQ-008 SHALL have port req_funct3, input, 3, RV32I width code.
REQ-009 SHALL have port req_addr / req_wdata, input, XLEN each, effective byte address and store data.
REQ-010 SHALL have port req_rd, input, RF_ADDR_WIDTH, load destination register.
REQ-011 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_we (output, 1), mem_addr (output, XLEN, word-aligned), mem_wdata (output, XLEN), mem_wmask (output, 4).
REQ-012 SHALL have ports mem_resp_valid (input, 1) and mem_rdata (input, XLEN); the response is always accepted in WAIT.
REQ-013 SHALL have ports wb_wen (output, 1), wb_waddr (output, RF_ADDR_WIDTH), wb_wdata (output, XLEN), driving the register-file write port directly.
REQ-014 SHALL have ports done (output, 1) and err (output, 1), one-cycle completion and fault pulses.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on req_valid & req_ready, latching all req_* fields; fields ignored in other states.
REQ-017 SHALL classify as error: both or neither of req_is_load/req_is_store; load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-018 SHALL, for an accepted error request, stay in IDLE, pulse err the next cycle, issue no memory request and assert neither wb_wen nor done.
REQ-019 SHALL, for a valid request, move IDLE->REQ and hold mem_req_valid=1 with stable mem_* fields until mem_req_ready=1, then move to WAIT.
REQ-020 SHALL drive mem_addr = {addr[31:2],2'b00}; mem_we = 1 for stores, 0 for loads.
REQ-021 SHALL drive for SB mem_wmask = 4'b0001<<addr[1:0] and mem_wdata = wdata[7:0] replicated 4x; for SH mem_wmask = 4'b0011<<addr[1:0] and mem_wdata = wdata[15:0] replicated 2x; for SW mask 4'b1111, data unmodified; loads mask 0.
REQ-022 SHALL, in WAIT, on mem_resp_valid return to IDLE and pulse done the following cycle.
REQ-023 SHALL select the load byte/halfword at offset addr[1:0] from mem_rdata; sign-extend for LB/LH, zero-extend for LBU/LHU; LW unmodified.
REQ-024 SHALL pulse wb_wen with wb_waddr=rd and wb_wdata=extended data in the same cycle as done, only for loads with rd!=0; stores never write back.
REQ-025 SHALL hold wb_waddr/wb_wdata at 0 whenever wb_wen=0.
REQ-026 SHALL give minimum latency: accept at T, mem_req_valid at T+1, WAIT at T+2 if ready at T+1, response at R>=T+2, done/wb_wen at R+1; next request accepted at R+1.
REQ-027 SHALL ignore mem_resp_valid outside WAIT and mem_req_ready outside REQ.

Reset
REQ-028 SHALL, while rst=1, force state IDLE and all outputs 0 except req_ready=1 after release; effect is immediate, not clock-gated.
REQ-029 SHALL, on reset in REQ or WAIT, abandon the transaction: no done, wb_wen or err for it; a late mem_resp_valid after reset is ignored.

Verification
REQ-030 SHALL cover LW x5 @0x80000004, ready at once, rdata 0xDEADBEEF 2 cycles later -> wb_wen=1, wb_waddr=5, wb_wdata=0xDEADBEEF, done same cycle.
REQ-031 SHALL cover LB @0x80000003 and LBU @0x80000003, rdata 0x80FF7F01 -> wb_wdata 0xFFFFFF80 and 0x00000080 respectively.
REQ-032 SHALL cover SH wdata 0x1234ABCD @0x80000002, mem_req_ready low 3 cycles -> mem_req_valid and fields stable 4 cycles, mem_wmask=4'b1100, mem_wdata=0xABCDABCD, done and no wb_wen after response.
REQ-033 SHALL cover LW @0x80000002 -> err pulse next cycle, mem_req_valid stays 0, req_ready stays 1.
REQ-034 SHALL cover LW to rd=0 -> done pulses, wb_wen stays 0.
REQ-035 SHALL cover rst asserted mid-WAIT, then mem_resp_valid -> outputs 0 immediately, no done/wb_wen, FSM in IDLE.
